instr_packer: RTL and testbench

Immediate encoder and instruction-memory loader for the reduced RISC-V core. Accepts an immediate, an `ImmSrc` selector and a base instruction word. Scatters the immediate into the instruction bit positions the control unit's immediate decoder reads back, and range-checks the immediate. Emits one packed word per accepted request through a one-entry valid/ready output register, tagged with an auto-incrementing instruction-memory write address. Used by the boot/program loader and as the encode-side reference for decoder round-trip checks.

---
 rtl/instr_packer.sv | 103 ++++++++++
 tb/tb_instr_packer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_packer.sv
// Immediate encoder and instruction-memory loader: scatters I/B-type immediates
// into a base instruction and streams packed words out with a write address.
module instr_packer #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  Clear,
  input  logic                  InValid,
  output logic                  InReady,
  input  logic [1:0]            ImmSrc,
  input  logic [DATA_WIDTH-1:0] Imm,
  input  logic [DATA_WIDTH-1:0] BaseInstr,
  output logic                  OutValid,
  input  logic                  OutReady,
  output logic [DATA_WIDTH-1:0] Instr,
  output logic [ADDR_WIDTH-1:0] WriteAddr,
  output logic                  RangeErr,
  output logic [7:0]            ErrCount,
  output logic                  Wrapped
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t                state_q;
  logic [DATA_WIDTH-1:0] instr_q;
  logic [DATA_WIDTH-1:0] instr_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  rangeErr_q;
  logic [7:0]            errCount_q;
  logic                  wrapped_q;
  logic                  immLegal;
  logic                  inFire;
  logic                  outFire;

  // Upper immediate bits must be pure sign extension of the encodable field.
  always_comb begin
    instr_d  = BaseInstr;
    immLegal = 1'b1;
    case (ImmSrc)
      2'b01: begin
        instr_d[31:20] = Imm[11:0];
        immLegal       = (&Imm[DATA_WIDTH-1:11]) | ~(|Imm[DATA_WIDTH-1:11]);
      end
      2'b11: begin
        instr_d[31]    = Imm[12];
        instr_d[7]     = Imm[11];
        instr_d[30:25] = Imm[10:5];
        instr_d[11:8]  = Imm[4:1];
        immLegal       = ((&Imm[DATA_WIDTH-1:12]) | ~(|Imm[DATA_WIDTH-1:12])) & ~Imm[0];
      end
      default: begin
        instr_d  = BaseInstr;
        immLegal = 1'b1;
      end
    endcase
  end

  assign OutValid  = (state_q == FULL);
  assign InReady   = ~Clear & (~OutValid | OutReady);
  assign inFire    = InValid & InReady;
  assign outFire   = OutValid & OutReady;
  assign Instr     = instr_q;
  assign WriteAddr = addr_q;
  assign RangeErr  = rangeErr_q;
  assign ErrCount  = errCount_q;
  assign Wrapped   = wrapped_q;

  always_ff @(posedge clk) begin
    if (!rst_n || Clear) begin
      state_q    <= EMPTY;
      instr_q    <= '0;
      addr_q     <= '0;
      rangeErr_q <= 1'b0;
      errCount_q <= 8'd0;
      wrapped_q  <= 1'b0;
    end else begin
      if (outFire) begin
        addr_q <= addr_q + 1'b1;
        if (&addr_q) begin
          wrapped_q <= 1'b1;
        end
      end

      // A rejected request completes its handshake but leaves the held word alone.
      if (inFire && immLegal) begin
        instr_q <= instr_d;
        state_q <= FULL;
      end else if (outFire) begin
        state_q <= EMPTY;
      end

      if (inFire && !immLegal) begin
        rangeErr_q <= 1'b1;
        if (errCount_q != 8'hFF) begin
          errCount_q <= errCount_q + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_packer.sv
// Self-checking bench for instr_packer: table-driven vectors feeding a
// scoreboard, plus hand-written backpressure, wrap, saturation, clear and reset sequences.
module tb_instr_packer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, Clear, InValid, OutReady;
  logic [1:0]  ImmSrc;
  logic [31:0] Imm, BaseInstr;
  logic        InReady, OutValid, RangeErr, Wrapped;
  logic [31:0] Instr;
  logic [7:0]  WriteAddr, ErrCount;
  logic        sInReady, sOutValid, sRangeErr, sWrapped;
  logic [31:0] sInstr;
  logic [1:0]  sWriteAddr;
  logic [7:0]  sErrCount;

  instr_packer #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .Clear(Clear), .InValid(InValid), .InReady(InReady),
    .ImmSrc(ImmSrc), .Imm(Imm), .BaseInstr(BaseInstr), .OutValid(OutValid),
    .OutReady(OutReady), .Instr(Instr), .WriteAddr(WriteAddr), .RangeErr(RangeErr),
    .ErrCount(ErrCount), .Wrapped(Wrapped)
  );

  // Narrow-address copy sharing the same stimulus, used to exercise wrap-around.
  instr_packer #(.DATA_WIDTH(32), .ADDR_WIDTH(2)) dutSmall (
    .clk(clk), .rst_n(rst_n), .Clear(Clear), .InValid(InValid), .InReady(sInReady),
    .ImmSrc(ImmSrc), .Imm(Imm), .BaseInstr(BaseInstr), .OutValid(sOutValid),
    .OutReady(OutReady), .Instr(sInstr), .WriteAddr(sWriteAddr), .RangeErr(sRangeErr),
    .ErrCount(sErrCount), .Wrapped(sWrapped)
  );

  typedef struct {
    logic [1:0]  src;
    logic [31:0] imm;
    logic [31:0] base;
    logic [31:0] expInstr;
    bit          legal;
  } vec_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] imm;
    logic [1:0]  src;
  } sb_t;

  sb_t        sbQ[$];
  vec_t       curVec;
  vec_t       vecs[13];
  vec_t       idle, reqA, reqB, reqC, badI;
  int         passed = 0;
  int         total = 0;
  logic [7:0] modAddr;
  logic [1:0] modAddrS;
  bit         modWrapped, modWrappedS, modRangeErr;
  int         modErr;

  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: actual 0x%08h required 0x%08h", name, act, exp);
  endtask

  function automatic logic [31:0] decodeImm(input logic [31:0] ins, input logic [1:0] src);
    if (src == 2'b01) return {{20{ins[31]}}, ins[31:20]};
    return {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
  endfunction

  task automatic applyStimulus(input bit valid, input vec_t v);
    InValid   = valid;
    ImmSrc    = v.src;
    Imm       = v.imm;
    BaseInstr = v.base;
    curVec    = v;
  endtask

  task automatic resetModel();
    sbQ.delete();
    modAddr     = 8'd0;
    modAddrS    = 2'd0;
    modWrapped  = 1'b0;
    modWrappedS = 1'b0;
    modRangeErr = 1'b0;
    modErr      = 0;
  endtask

  // Compares outputs mid-cycle against the model, then advances one clock.
  task automatic checkOutput();
    bit  modValid, expReady, hs, acc;
    sb_t e;
    #4;
    modValid = (sbQ.size() != 0);
    expReady = !Clear && (!modValid || OutReady);
    if (rst_n) compare("InReady", 32'(InReady), 32'(expReady));
    compare("OutValid", 32'(OutValid), 32'(modValid));
    compare("ErrCount", 32'(ErrCount), 32'(modErr));
    compare("RangeErr", 32'(RangeErr), 32'(modRangeErr));
    compare("Wrapped", 32'(Wrapped), 32'(modWrapped));
    compare("WrappedSmall", 32'(sWrapped), 32'(modWrappedS));
    hs  = modValid && OutReady;
    acc = InValid && expReady;
    if (hs) begin
      e = sbQ.pop_front();
      compare("Instr", Instr, e.instr);
      compare("WriteAddr", 32'(WriteAddr), 32'(modAddr));
      compare("WriteAddrSmall", 32'(sWriteAddr), 32'(modAddrS));
      if (e.src == 2'b01 || e.src == 2'b11)
        compare("RoundTrip", decodeImm(Instr, e.src), e.imm);
    end
    @(posedge clk);
    #1;
    if (!rst_n || Clear) begin
      resetModel();
    end else begin
      if (hs) begin
        if (modAddr == 8'hFF) modWrapped = 1'b1;
        modAddr = modAddr + 8'd1;
        if (modAddrS == 2'b11) modWrappedS = 1'b1;
        modAddrS = modAddrS + 2'd1;
      end
      if (acc) begin
        if (curVec.legal) begin
          sbQ.push_back('{instr: curVec.expInstr, imm: curVec.imm, src: curVec.src});
        end else begin
          modRangeErr = 1'b1;
          if (modErr < 255) modErr++;
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual timeout required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    idle  = '{src: 2'b00, imm: 32'h0, base: 32'h0, expInstr: 32'h0, legal: 1'b1};
    reqA  = '{src: 2'b01, imm: 32'h00000123, base: 32'h00000013, expInstr: 32'h12300013, legal: 1'b1};
    reqB  = '{src: 2'b11, imm: 32'hFFFFFFFE, base: 32'h00000063, expInstr: 32'hFE000FE3, legal: 1'b1};
    reqC  = '{src: 2'b00, imm: 32'h00000055, base: 32'hCAFEF00D, expInstr: 32'hCAFEF00D, legal: 1'b1};
    badI  = '{src: 2'b01, imm: 32'h00000800, base: 32'h00000013, expInstr: 32'h0, legal: 1'b0};

    vecs[0]  = '{src: 2'b01, imm: 32'hFFFFF800, base: 32'h00000013, expInstr: 32'h80000013, legal: 1'b1};
    vecs[1]  = '{src: 2'b11, imm: 32'hFFFFF000, base: 32'h00000063, expInstr: 32'h80000063, legal: 1'b1};
    vecs[2]  = '{src: 2'b11, imm: 32'h00000800, base: 32'h00000063, expInstr: 32'h000000E3, legal: 1'b1};
    vecs[3]  = '{src: 2'b01, imm: 32'h00000800, base: 32'h00000013, expInstr: 32'h0, legal: 1'b0};
    vecs[4]  = '{src: 2'b11, imm: 32'h00000003, base: 32'h00000063, expInstr: 32'h0, legal: 1'b0};
    vecs[5]  = '{src: 2'b01, imm: 32'h000007FF, base: 32'h00000093, expInstr: 32'h7FF00093, legal: 1'b1};
    vecs[6]  = '{src: 2'b00, imm: 32'hDEADBEEF, base: 32'h12345678, expInstr: 32'h12345678, legal: 1'b1};
    vecs[7]  = '{src: 2'b10, imm: 32'h00000000, base: 32'hFFFFFFFF, expInstr: 32'hFFFFFFFF, legal: 1'b1};
    vecs[8]  = '{src: 2'b11, imm: 32'h00000FFE, base: 32'h00000063, expInstr: 32'h7E000FE3, legal: 1'b1};
    vecs[9]  = '{src: 2'b11, imm: 32'h00000000, base: 32'hFFFFFFFF, expInstr: 32'h01FFF07F, legal: 1'b1};
    vecs[10] = '{src: 2'b01, imm: 32'hFFFFF801, base: 32'hFFFFFFFF, expInstr: 32'h801FFFFF, legal: 1'b1};
    vecs[11] = '{src: 2'b01, imm: 32'hFFFFF7FF, base: 32'h00000013, expInstr: 32'h0, legal: 1'b0};
    vecs[12] = '{src: 2'b11, imm: 32'h00001000, base: 32'h00000063, expInstr: 32'h0, legal: 1'b0};

    rst_n = 1'b0; Clear = 1'b0; OutReady = 1'b1;
    applyStimulus(1'b0, idle);
    resetModel();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    compare("rstOutValid", 32'(OutValid), 32'd0);
    compare("rstInstr", Instr, 32'd0);
    compare("rstWriteAddr", 32'(WriteAddr), 32'd0);
    compare("rstErrCount", 32'(ErrCount), 32'd0);
    compare("rstRangeErr", 32'(RangeErr), 32'd0);
    compare("rstWrapped", 32'(Wrapped), 32'd0);
    compare("rstInReady", 32'(InReady), 32'd1);
    @(posedge clk);
    #1;

    // Table vectors at full throughput.
    foreach (vecs[i]) begin
      applyStimulus(1'b1, vecs[i]);
      checkOutput();
    end
    applyStimulus(1'b0, idle);
    repeat (2) checkOutput();
    compare("tableErrCount", 32'(ErrCount), 32'd4);
    compare("tableWriteAddr", 32'(WriteAddr), 32'd9);

    Clear = 1'b1;
    checkOutput();
    Clear = 1'b0;

    // Backpressure: held word must stay put while the consumer stalls.
    OutReady = 1'b0;
    applyStimulus(1'b1, reqA);
    checkOutput();
    applyStimulus(1'b1, reqB);
    repeat (2) checkOutput();
    compare("stallInstr", Instr, 32'h12300013);
    compare("stallInReady", 32'(InReady), 32'd0);
    compare("stallWriteAddr", 32'(WriteAddr), 32'd0);
    OutReady = 1'b1;
    checkOutput();
    applyStimulus(1'b1, reqC);
    checkOutput();
    applyStimulus(1'b0, idle);
    repeat (2) checkOutput();
    compare("bpWriteAddr", 32'(WriteAddr), 32'd3);

    // Wrap on the 2-bit address copy.
    Clear = 1'b1;
    checkOutput();
    Clear = 1'b0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, vecs[i % 3]);
      checkOutput();
    end
    applyStimulus(1'b0, idle);
    repeat (2) checkOutput();
    compare("wrapSmall", 32'(sWrapped), 32'd1);
    compare("wrapSmallAddr", 32'(sWriteAddr), 32'd1);
    compare("wrapMainClear", 32'(Wrapped), 32'd0);
    compare("wrapMainAddr", 32'(WriteAddr), 32'd5);

    // Error counter saturation.
    applyStimulus(1'b1, badI);
    repeat (300) checkOutput();
    applyStimulus(1'b0, idle);
    checkOutput();
    compare("errSat", 32'(ErrCount), 32'd255);
    compare("errSatRange", 32'(RangeErr), 32'd1);
    compare("errSatAddr", 32'(WriteAddr), 32'd5);

    // Clear while a word is held and a request is pending.
    OutReady = 1'b0;
    applyStimulus(1'b1, reqA);
    checkOutput();
    Clear = 1'b1;
    applyStimulus(1'b1, reqB);
    checkOutput();
    Clear = 1'b0;
    applyStimulus(1'b0, idle);
    compare("clrOutValid", 32'(OutValid), 32'd0);
    compare("clrInstr", Instr, 32'd0);
    compare("clrWriteAddr", 32'(WriteAddr), 32'd0);
    compare("clrErrCount", 32'(ErrCount), 32'd0);
    compare("clrRangeErr", 32'(RangeErr), 32'd0);
    compare("clrWrappedSmall", 32'(sWrapped), 32'd0);
    checkOutput();

    // Reset in the middle of a stream.
    OutReady = 1'b1;
    applyStimulus(1'b1, badI);
    checkOutput();
    applyStimulus(1'b1, reqA);
    checkOutput();
    applyStimulus(1'b1, reqB);
    checkOutput();
    OutReady = 1'b0;
    applyStimulus(1'b0, idle);
    checkOutput();
    compare("preRstAddr", 32'(WriteAddr), 32'd1);
    rst_n = 1'b0;
    applyStimulus(1'b1, reqC);
    checkOutput();
    rst_n = 1'b1;
    applyStimulus(1'b0, idle);
    compare("midRstOutValid", 32'(OutValid), 32'd0);
    compare("midRstInstr", Instr, 32'd0);
    compare("midRstWriteAddr", 32'(WriteAddr), 32'd0);
    compare("midRstErrCount", 32'(ErrCount), 32'd0);
    compare("midRstRangeErr", 32'(RangeErr), 32'd0);
    checkOutput();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
